// File: rtl/ttl_74173_bus_sequencer_pkg.sv
// Shared definitions for the 74173 bus sequencer: FSM state encoding and
// the helper that pulls one requester's register index out of a packed vector.
package ttl_74173_bus_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_DRIVE   = 2'd1;
  localparam state_t ST_LOAD    = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  localparam int MAX_VEC = 256;
  localparam int MAX_SEL = 8;

  // Callers zero-extend their packed vector to MAX_VEC and truncate the result.
  function automatic logic [MAX_SEL-1:0] unpack_idx(input logic [MAX_VEC-1:0] vec,
                                                    input int unsigned         idx,
                                                    input int unsigned         width);
    logic [MAX_SEL-1:0] mask;
    mask = (MAX_SEL'(1) << width) - MAX_SEL'(1);
    return MAX_SEL'(vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/ttl_74173_bus_sequencer_if.sv
// Request/grant handshake plus the 74173 enable lines of the shared bus.
// The requester side is the master; the sequencer is the slave.
interface ttl_74173_bus_sequencer_if #(
  parameter int NUM_REGS  = 4,
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2
) ();
  logic [NUM_REQ-1:0]           Req;
  logic [NUM_REQ*SEL_WIDTH-1:0] Req_Src;
  logic [NUM_REQ*SEL_WIDTH-1:0] Req_Dst;
  logic [NUM_REQ-1:0]           Grant;
  logic [NUM_REQ-1:0]           Done;
  logic                         Err;
  logic [NUM_REGS-1:0]          OE_Bar;
  logic [NUM_REGS-1:0]          Load_Bar;
  logic                         Busy;

  modport master (
    output Req, Req_Src, Req_Dst,
    input  Grant, Done, Err, OE_Bar, Load_Bar, Busy
  );

  modport slave (
    input  Req, Req_Src, Req_Dst,
    output Grant, Done, Err, OE_Bar, Load_Bar, Busy
  );
endinterface

// File: rtl/ttl_74173_bus_sequencer_arbiter.sv
// Combinational round-robin arbiter: first set request at or after the
// pointer, wrapping. The pointer register is owned by the sequencer.
module ttl_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_i) + k) % NUM_REQ;
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ttl_74173_bus_sequencer.sv
// Sequences register-to-register transfers over a shared tri-state bus of
// 74173 quad registers, guaranteeing a single driver and a turnaround cycle.
module ttl_74173_bus_sequencer
  import ttl_74173_bus_sequencer_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      Clk,
  input  logic                      Rst_Bar,
  ttl_74173_bus_sequencer_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] src_q, src_d;
  logic [SEL_WIDTH-1:0] dst_q, dst_d;
  logic                 inv_q, inv_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic [NUM_REGS-1:0]  oe_bar_q, oe_bar_d;
  logic [NUM_REGS-1:0]  load_bar_q, load_bar_d;
  logic                 busy_q, busy_d;

  logic                 arb_en;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic [SEL_WIDTH-1:0] req_src_sel, req_dst_sel;
  logic                 req_invalid;
  logic [NUM_REGS-1:0]  src_hit, dst_hit;

  assign arb_en = (state_q == ST_IDLE);

  ttl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (bus.Req),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign req_src_sel = SEL_WIDTH'(unpack_idx(MAX_VEC'(bus.Req_Src), 32'(arb_idx), SEL_WIDTH));
  assign req_dst_sel = SEL_WIDTH'(unpack_idx(MAX_VEC'(bus.Req_Dst), 32'(arb_idx), SEL_WIDTH));

  // A self-copy or an index past the last register is answered with Err only.
  assign req_invalid = (req_src_sel == req_dst_sel)
                    || (32'(req_src_sel) >= NUM_REGS)
                    || (32'(req_dst_sel) >= NUM_REGS);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
    assign src_hit[gi] = (src_d == SEL_WIDTH'(gi));
    assign dst_hit[gi] = (dst_d == SEL_WIDTH'(gi));
  end

  always_ff @(posedge Clk or negedge Rst_Bar) begin
    if (!Rst_Bar) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      inv_q      <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      oe_bar_q   <= '1;
      load_bar_q <= '1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      inv_q      <= inv_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      oe_bar_q   <= oe_bar_d;
      load_bar_q <= load_bar_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    inv_d   = inv_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          gnt_d   = arb_grant;
          src_d   = req_src_sel;
          dst_d   = req_dst_sel;
          inv_d   = req_invalid;
          ptr_d   = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          state_d = req_invalid ? ST_RELEASE : ST_DRIVE;
        end
      end
      ST_DRIVE:   state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RELEASE;
      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    oe_bar_d   = '1;
    load_bar_d = '1;
    done_d     = '0;
    err_d      = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    case (state_d)
      ST_DRIVE: oe_bar_d = ~src_hit;
      ST_LOAD: begin
        oe_bar_d   = ~src_hit;
        load_bar_d = ~dst_hit;
      end
      ST_RELEASE: begin
        done_d = gnt_d;
        err_d  = inv_d;
      end
      default: ;
    endcase
  end

  assign bus.Grant    = gnt_q;
  assign bus.Done     = done_q;
  assign bus.Err      = err_q;
  assign bus.OE_Bar   = oe_bar_q;
  assign bus.Load_Bar = load_bar_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_ttl_74173_bus_sequencer.sv
// Bench for the 74173 bus sequencer: transaction-level schedule model,
// attached 74173 register bank, bus invariants, directed and random traffic.
module tb_ttl_74173_bus_sequencer;

  localparam int NREG = 4;
  localparam int NREQ = 4;
  localparam int SW   = 2;

  logic Clk     = 1'b0;
  logic Rst_Bar = 1'b1;
  always #5 Clk = ~Clk;

  ttl_74173_bus_sequencer_if #(.NUM_REGS(NREG), .NUM_REQ(NREQ), .SEL_WIDTH(SW)) bus_if ();

  ttl_74173_bus_sequencer #(.NUM_REGS(NREG), .NUM_REQ(NREQ), .SEL_WIDTH(SW)) dut (
    .Clk     (Clk),
    .Rst_Bar (Rst_Bar),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected per-cycle outputs of one transaction.
  typedef struct {
    logic [3:0] grant;
    logic [3:0] done;
    logic       err;
    logic [3:0] oe;
    logic [3:0] ld;
    logic       busy;
    logic       chk_data;
    int         dst;
    logic [3:0] data;
  } exp_t;

  function automatic exp_t idle_e();
    exp_t e;
    e.grant = '0; e.done = '0; e.err = 1'b0; e.oe = '1; e.ld = '1; e.busy = 1'b0;
    e.chk_data = 1'b0; e.dst = 0; e.data = '0;
    return e;
  endfunction

  exp_t       sched[$];
  exp_t       cur;
  exp_t       m_e;
  int         m_ptr = 0;
  int         m_sel, m_s, m_d, m_drv, m_nlow;
  logic [3:0] m_g;
  logic [3:0] hw_reg[4] = '{4'hA, 4'h5, 4'hC, 4'h3};
  logic [3:0] oe_s = '1;
  logic [3:0] ld_s = '1;

  // Model: the 74173 bank captures on the edge, then the schedule advances.
  always @(posedge Clk or negedge Rst_Bar) begin
    if (!Rst_Bar) begin
      sched.delete();
      cur   = idle_e();
      m_ptr = 0;
    end else begin
      m_drv = -1; m_nlow = 0;
      for (int r = 0; r < NREG; r++) if (!oe_s[r]) begin m_drv = r; m_nlow++; end
      if (m_nlow == 1)
        for (int r = 0; r < NREG; r++) if (!ld_s[r]) hw_reg[r] = hw_reg[m_drv];
      if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else begin
        cur = idle_e();
        if (|bus_if.Req) begin
          m_sel = -1;
          for (int k = 0; k < NREQ; k++)
            if (m_sel < 0 && bus_if.Req[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
          m_ptr = (m_sel + 1) % NREQ;
          m_s   = int'(bus_if.Req_Src[m_sel*SW +: SW]);
          m_d   = int'(bus_if.Req_Dst[m_sel*SW +: SW]);
          m_g   = '0; m_g[m_sel] = 1'b1;
          m_e   = idle_e(); m_e.grant = m_g; m_e.busy = 1'b1;
          if (m_s == m_d || m_s >= NREG || m_d >= NREG) begin
            m_e.done = m_g; m_e.err = 1'b1;
            sched.push_back(m_e);
          end else begin
            m_e.oe[m_s] = 1'b0;
            sched.push_back(m_e);
            m_e.ld[m_d] = 1'b0;
            sched.push_back(m_e);
            m_e.oe = '1; m_e.ld = '1; m_e.done = m_g;
            m_e.chk_data = 1'b1; m_e.dst = m_d; m_e.data = hw_reg[m_s];
            sched.push_back(m_e);
          end
          sched.push_back(idle_e());
          cur = sched.pop_front();
        end
      end
    end
  end

  int prev_drv = -1;

  always @(negedge Clk) begin
    int oe_low, ld_low, drv;
    chk("grant",    32'(bus_if.Grant),    32'(cur.grant));
    chk("done",     32'(bus_if.Done),     32'(cur.done));
    chk("err",      32'(bus_if.Err),      32'(cur.err));
    chk("oe_bar",   32'(bus_if.OE_Bar),   32'(cur.oe));
    chk("load_bar", 32'(bus_if.Load_Bar), 32'(cur.ld));
    chk("busy",     32'(bus_if.Busy),     32'(cur.busy));
    oe_low = 0; ld_low = 0; drv = -1;
    for (int r = 0; r < NREG; r++) begin
      if (!bus_if.OE_Bar[r]) begin oe_low++; drv = r; end
      if (!bus_if.Load_Bar[r]) ld_low++;
    end
    chk("single_driver", 32'(oe_low <= 1), 32'(1));
    chk("single_load",   32'(ld_low <= 1), 32'(1));
    chk("load_under_oe", 32'(ld_low == 0 || oe_low == 1), 32'(1));
    if (prev_drv >= 0 && drv >= 0) chk("turnaround", 32'(drv), 32'(prev_drv));
    prev_drv = drv;
    if (cur.chk_data) chk("dest_data", 32'(hw_reg[cur.dst]), 32'(cur.data));
    oe_s = bus_if.OE_Bar;
    ld_s = bus_if.Load_Bar;
  end

  task automatic wait_done(output logic [3:0] d);
    int n;
    n = 0;
    while (bus_if.Done == '0 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    d = bus_if.Done;
    if (n >= 10) begin
      n_checks++;
      $display("FAIL done_timeout: got Done=0x%0h after %0d cycles, expected a pulse", d, n);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk); #2 Rst_Bar = 1'b0;
    @(negedge Clk); #2 Rst_Bar = 1'b1;
  endtask

  logic [3:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] d;
  logic       in_rst;

  initial begin
    bus_if.Req = '0; bus_if.Req_Src = '0; bus_if.Req_Dst = '0;
    #1 Rst_Bar = 1'b0;
    @(negedge Clk);
    chk("rst_oe", 32'(bus_if.OE_Bar), 32'(4'b1111));
    chk("rst_ld", 32'(bus_if.Load_Bar), 32'(4'b1111));
    chk("rst_busy", 32'(bus_if.Busy), 32'(0));
    chk("rst_grant", 32'(bus_if.Grant), 32'(0));
    #2 Rst_Bar = 1'b1;

    // Single transfer reg2 -> reg1.
    @(negedge Clk);
    bus_if.Req = 4'b0001; bus_if.Req_Src[1:0] = 2'd2; bus_if.Req_Dst[1:0] = 2'd1;
    @(negedge Clk);
    chk("t1_drive_oe", 32'(bus_if.OE_Bar), 32'(4'b1011));
    chk("t1_drive_ld", 32'(bus_if.Load_Bar), 32'(4'b1111));
    chk("t1_grant", 32'(bus_if.Grant), 32'(4'b0001));
    @(negedge Clk);
    chk("t1_load_oe", 32'(bus_if.OE_Bar), 32'(4'b1011));
    chk("t1_load_ld", 32'(bus_if.Load_Bar), 32'(4'b1101));
    @(negedge Clk);
    chk("t1_done", 32'(bus_if.Done), 32'(4'b0001));
    chk("t1_rel_oe", 32'(bus_if.OE_Bar), 32'(4'b1111));
    chk("t1_reg1", 32'(hw_reg[1]), 32'(4'hC));
    bus_if.Req = '0;
    @(negedge Clk);
    chk("t1_idle_busy", 32'(bus_if.Busy), 32'(0));

    // Round robin from pointer 0 with all four requests held.
    do_reset();
    @(negedge Clk);
    bus_if.Req_Src = 8'b11_10_01_00;
    bus_if.Req_Dst = 8'b00_11_10_01;
    bus_if.Req     = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(d);
      chk($sformatf("rr_order%0d", j), 32'(d), 32'(rr_exp[j]));
      if (j == 4) bus_if.Req = '0;
      @(negedge Clk);
    end

    // Invalid request: self-copy of reg3.
    bus_if.Req = 4'b0100; bus_if.Req_Src[5:4] = 2'd3; bus_if.Req_Dst[5:4] = 2'd3;
    @(negedge Clk);
    chk("inv_done", 32'(bus_if.Done), 32'(4'b0100));
    chk("inv_err", 32'(bus_if.Err), 32'(1));
    chk("inv_oe", 32'(bus_if.OE_Bar), 32'(4'b1111));
    chk("inv_ld", 32'(bus_if.Load_Bar), 32'(4'b1111));
    bus_if.Req = '0;
    @(negedge Clk);
    chk("inv_idle_busy", 32'(bus_if.Busy), 32'(0));

    // Request churn: Req dropped and Src changed after the grant.
    bus_if.Req = 4'b0001; bus_if.Req_Src[1:0] = 2'd0; bus_if.Req_Dst[1:0] = 2'd3;
    @(negedge Clk);
    chk("ch_drive_oe", 32'(bus_if.OE_Bar), 32'(4'b1110));
    bus_if.Req = '0; bus_if.Req_Src[1:0] = 2'd1;
    @(negedge Clk);
    chk("ch_load_oe", 32'(bus_if.OE_Bar), 32'(4'b1110));
    chk("ch_load_ld", 32'(bus_if.Load_Bar), 32'(4'b0111));
    @(negedge Clk);
    chk("ch_done", 32'(bus_if.Done), 32'(4'b0001));
    chk("ch_reg3", 32'(hw_reg[3]), 32'(4'hA));
    @(negedge Clk);

    // Reset in the middle of LOAD.
    bus_if.Req = 4'b0010; bus_if.Req_Src[3:2] = 2'd3; bus_if.Req_Dst[3:2] = 2'd2;
    @(negedge Clk);
    chk("rs_drive_oe", 32'(bus_if.OE_Bar), 32'(4'b0111));
    @(negedge Clk);
    chk("rs_load_ld", 32'(bus_if.Load_Bar), 32'(4'b1011));
    #2 Rst_Bar = 1'b0;
    #1;
    chk("rs_oe", 32'(bus_if.OE_Bar), 32'(4'b1111));
    chk("rs_ld", 32'(bus_if.Load_Bar), 32'(4'b1111));
    chk("rs_busy", 32'(bus_if.Busy), 32'(0));
    bus_if.Req = '0;
    @(negedge Clk);
    chk("rs_no_done", 32'(bus_if.Done), 32'(0));
    #2 Rst_Bar = 1'b1;

    // Random traffic with occasional resets.
    in_rst = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge Clk);
      if (in_rst) begin
        #2 Rst_Bar = 1'b1;
        in_rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        #2 Rst_Bar = 1'b0;
        in_rst = 1'b1;
        bus_if.Req = '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (bus_if.Req[i] && bus_if.Done[i]) begin
            bus_if.Req[i] = 1'b0;
          end else if (!bus_if.Req[i] && $urandom_range(0, 3) == 0) begin
            bus_if.Req_Src[i*SW +: SW] = SW'($urandom_range(0, 3));
            bus_if.Req_Dst[i*SW +: SW] = SW'($urandom_range(0, 3));
            bus_if.Req[i] = 1'b1;
          end
        end
      end
    end
    #2 Rst_Bar = 1'b1;
    bus_if.Req = '0;
    @(negedge Clk);
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ttl_74173_bus_sequencer.md
Name: ttl_74173_bus_sequencer

Overview:
Sequences register-to-register transfers over one shared tri-state bus built from 74173-style quad registers. Each register has an output enable (M_Bar/N_Bar) and a load enable (G1_Bar; G2_Bar tied low).
- Up to NUM_REQ requesters each post a (source, destination) transfer.
- A round-robin arbiter grants one request at a time.
- An FSM drives the source onto the bus, loads the destination, then inserts a turnaround cycle.
- Guarantees at most one bus driver at any time.

Parameters:
NUM_REGS, 4, number of 74173 registers on the shared bus
NUM_REQ, 4, number of transfer requesters
SEL_WIDTH, 2, width of a register index (clog2 of NUM_REGS, minimum 1)

Ports:
Clk  input  1  system clock, rising-edge active; same clock as the 74173 registers
Rst_Bar  input  1  asynchronous active-low reset
Req  input  NUM_REQ  per-requester request, level; held until matching Done
Req_Src  input  NUM_REQ*SEL_WIDTH  packed source register index per requester (requester i at bits [i*SEL_WIDTH +: SEL_WIDTH])
Req_Dst  input  NUM_REQ*SEL_WIDTH  packed destination register index per requester, same packing
Grant  output  NUM_REQ  one-hot; identifies the requester being serviced
Done  output  NUM_REQ  one-hot, one-cycle pulse when the granted transfer finishes
Err  output  1  one-cycle pulse, coincident with Done, when the transfer was rejected
OE_Bar  output  NUM_REGS  active-low output enable per register; drives both M_Bar and N_Bar
Load_Bar  output  NUM_REGS  active-low load enable per register; drives G1_Bar
Busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered.
- Reset (Rst_Bar low, asynchronous, takes effect immediately):
  - state=IDLE, RR pointer=0
  - OE_Bar all 1, Load_Bar all 1
  - Grant=0, Done=0, Err=0, Busy=0
  - Reset mid-transfer releases the bus at once. The aborted transfer gets no Done; the requester re-posts.
- States: IDLE, DRIVE, LOAD, RELEASE.
- IDLE:
  - If any Req bit is set, pick the first set bit at or after the RR pointer, wrapping.
  - Register Grant (one-hot) and latch that requester's Src/Dst.
  - RR pointer becomes granted index+1, modulo NUM_REQ.
  - Invalid request (Src==Dst, or Src/Dst >= NUM_REGS): go to RELEASE with Err flagged; no OE_Bar or Load_Bar activity.
  - Valid request: go to DRIVE.
- DRIVE (1 cycle): OE_Bar[Src]=0 so the bus settles. Next state LOAD.
- LOAD (1 cycle):
  - OE_Bar[Src] stays 0; Load_Bar[Dst]=0.
  - The destination captures at the rising edge that ends LOAD.
  - Next state RELEASE.
- RELEASE (1 cycle):
  - OE_Bar all 1, Load_Bar all 1.
  - Done[granted]=1; Err=1 if the request was invalid.
  - Next state IDLE, Grant cleared.
- Cycle counts:
  - Valid transfer: 4 cycles (IDLE grant, DRIVE, LOAD, RELEASE).
  - Invalid transfer: 2 cycles (IDLE grant, RELEASE).
- Handshake:
  - Src/Dst are sampled only at grant; later changes are ignored.
  - Req dropped after grant: the transfer still completes and Done still pulses.
  - Requester must deassert Req in the cycle after Done, or it will be re-arbitrated.
- Invariants, always true:
  - At most one OE_Bar bit low.
  - At most one Load_Bar bit low.
  - A Load_Bar bit is low only while the source OE_Bar bit is low.
  - At least one all-high OE_Bar cycle (RELEASE) between consecutive drivers.
- New requests arriving while Busy wait; arbitration happens only in IDLE.

Decomposition:
- Shared package/include holds:
  - state encoding localparams (IDLE=2'd0, DRIVE=2'd1, LOAD=2'd2, RELEASE=2'd3)
  - the index-unpack helper for packed Src/Dst vectors
- One sub-module, ttl_rr_arbiter:
  - inputs: NUM_REQ request vector, pointer, enable
  - outputs: one-hot grant, binary grant index
  - combinational; the pointer register lives in the sequencer

Test Plan:
- Reset/idle: Rst_Bar low mid-LOAD → OE_Bar=4'b1111, Load_Bar=4'b1111, Busy=0 immediately; no Done.
- Single transfer: Req=4'b0001, Src0=2, Dst0=1 → DRIVE OE_Bar=4'b1011; LOAD OE_Bar=4'b1011 with Load_Bar=4'b1101; RELEASE Done=4'b0001, all enables high; attached 74173 model reg1 equals reg2.
- Round-robin: Req=4'b1111 held (each re-asserted after Done) → grant order 0,1,2,3,0; pointer wraps from 3 to 0.
- Invalid: Req=4'b0100, Src2=Dst2=3 → next cycle Done=4'b0100, Err=1; OE_Bar/Load_Bar never leave 4'b1111; total 2 cycles.
- Request churn: Req0 dropped during DRIVE and Src0 changed → transfer uses the latched Src, Done[0] still pulses.
- Bus-contention monitor over 10k random requests with random resets → no cycle with two OE_Bar bits low; Load_Bar only under a low OE_Bar; every valid Done matches the register-model data.
